// File: rtl/ps2_drive_decoder.sv
// PS/2 scan-set-2 receiver that turns held keys into per-player
// steering, throttle and boost levels for two physics engines.
module ps2_drive_decoder #(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [1:0] p1_h_code,
    output logic [1:0] p1_v_code,
    output logic       p1_boost,
    output logic [1:0] p2_h_code,
    output logic [1:0] p2_v_code,
    output logic       p2_boost,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    if (CLK_FREQ < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("ps2_drive_decoder: CLK_FREQ and TIMEOUT_CYCLES must be positive");
    end

    localparam int K_W  = 0;
    localparam int K_A  = 1;
    localparam int K_S  = 2;
    localparam int K_D  = 3;
    localparam int K_LS = 4;
    localparam int K_UP = 5;
    localparam int K_LT = 6;
    localparam int K_DN = 7;
    localparam int K_RT = 8;
    localparam int K_RS = 9;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          fall;
    logic [2:0]    bit_cnt;
    logic [7:0]    sreg;
    logic          par;
    logic [TW-1:0] tcnt;
    logic          ext;
    logic          brk;
    logic [9:0]    keys;
    logic          key_hit;
    logic [3:0]    key_idx;

    // Lines idle high, so the synchronizer resets to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall = clk_prev & ~clk_sync[1];

    always_comb begin
        key_hit = 1'b1;
        key_idx = 4'd0;
        unique case ({ext, sreg})
            {1'b0, 8'h1D}: key_idx = 4'(K_W);
            {1'b0, 8'h1C}: key_idx = 4'(K_A);
            {1'b0, 8'h1B}: key_idx = 4'(K_S);
            {1'b0, 8'h23}: key_idx = 4'(K_D);
            {1'b0, 8'h12}: key_idx = 4'(K_LS);
            {1'b1, 8'h75}: key_idx = 4'(K_UP);
            {1'b1, 8'h6B}: key_idx = 4'(K_LT);
            {1'b1, 8'h72}: key_idx = 4'(K_DN);
            {1'b1, 8'h74}: key_idx = 4'(K_RT);
            {1'b0, 8'h59}: key_idx = 4'(K_RS);
            default:       key_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            sreg       <= '0;
            par        <= 1'b0;
            tcnt       <= '0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            keys       <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                unique case (state)
                    IDLE: begin
                        if (!data_sync[1]) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                            ext       <= 1'b0;
                            brk       <= 1'b0;
                        end
                    end
                    DATA: begin
                        sreg    <= {data_sync[1], sreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= data_sync[1];
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (data_sync[1] && ^{sreg, par}) begin
                            byte_valid <= 1'b1;
                            byte_data  <= sreg;
                            if (sreg == 8'hE0) begin
                                ext <= 1'b1;
                            end else if (sreg == 8'hF0) begin
                                brk <= 1'b1;
                            end else begin
                                if (key_hit) keys[key_idx] <= !brk;
                                ext <= 1'b0;
                                brk <= 1'b0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            ext       <= 1'b0;
                            brk       <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tcnt == TMAX) begin
                    state     <= IDLE;
                    frame_err <= 1'b1;
                    ext       <= 1'b0;
                    brk       <= 1'b0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

    function automatic logic [1:0] axis(input logic neg, input logic pos);
        axis = (neg && !pos) ? 2'd1 : (pos && !neg) ? 2'd2 : 2'd0;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_h_code <= '0;
            p1_v_code <= '0;
            p1_boost  <= 1'b0;
            p2_h_code <= '0;
            p2_v_code <= '0;
            p2_boost  <= 1'b0;
        end else begin
            p1_h_code <= axis(keys[K_A], keys[K_D]);
            p1_v_code <= axis(keys[K_W], keys[K_S]);
            p1_boost  <= keys[K_LS];
            p2_h_code <= axis(keys[K_LT], keys[K_RT]);
            p2_v_code <= axis(keys[K_UP], keys[K_DN]);
            p2_boost  <= keys[K_RS];
        end
    end

endmodule

// File: tb/tb_ps2_drive_decoder.sv
// Scoreboard bench for ps2_drive_decoder: frames driven bit by bit,
// accepted bytes checked against a queue, player outputs checked after each frame.
module tb_ps2_drive_decoder;

    localparam int TO   = 200;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [1:0] p1_h_code, p1_v_code, p2_h_code, p2_v_code;
    logic       p1_boost, p2_boost;
    logic       byte_valid, frame_err;
    logic [7:0] byte_data;

    int         tests = 0;
    int         fails = 0;
    int         err_cnt = 0;
    logic [7:0] exp_q[$];

    ps2_drive_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .p1_h_code(p1_h_code), .p1_v_code(p1_v_code), .p1_boost(p1_boost),
        .p2_h_code(p2_h_code), .p2_v_code(p2_v_code), .p2_boost(p2_boost),
        .byte_valid(byte_valid), .byte_data(byte_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && frame_err) err_cnt++;
        if (!rst && byte_valid) begin
            if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, byte_data}, 32'hFFFF);
            else chk("byte", {24'd0, byte_data}, {24'd0, exp_q.pop_front()});
        end
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par);
        if (!bad_par) exp_q.push_back(b);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ bad_par);
        ps2_bit(1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic key(input logic [7:0] b);
        send(b, 1'b0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {p1_h_code, p1_v_code, p1_boost, p2_h_code, p2_v_code, p2_boost}, 0);
        chk("rst_byte", {byte_valid, frame_err, byte_data}, 0);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        key(8'h1D);
        chk("w_make", p1_v_code, 1);
        chk("p2_idle_a", {p2_h_code, p2_v_code, p2_boost}, 0);
        key(8'hF0); key(8'h1D);
        chk("w_break", p1_v_code, 0);
        chk("p2_idle_b", {p2_h_code, p2_v_code, p2_boost}, 0);

        key(8'hE0); key(8'h6B);
        chk("p2_left", p2_h_code, 1);
        key(8'hE0); key(8'h74);
        chk("p2_both", p2_h_code, 0);
        key(8'hE0); key(8'hF0); key(8'h6B);
        chk("p2_right", p2_h_code, 2);

        key(8'hE0); key(8'h12);
        chk("ext_lshift", p1_boost, 0);
        key(8'h12);
        chk("lshift", p1_boost, 1);
        key(8'h59);
        chk("rshift", p2_boost, 1);

        send(8'h1C, 1'b1);
        chk("par_err_cnt", err_cnt, 1);
        chk("par_no_key", p1_h_code, 0);
        key(8'h1C);
        chk("a_make", p1_h_code, 1);
        key(8'hF0); key(8'h1C);
        chk("a_break", p1_h_code, 0);

        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TO + 10) @(posedge clk);
        @(negedge clk);
        chk("timeout_err_cnt", err_cnt, 2);
        key(8'h23);
        chk("d_make", p1_h_code, 2);

        key(8'h1D);
        chk("hold_w", p1_v_code, 1);
        chk("hold_d", p1_h_code, 2);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_p1", {p1_h_code, p1_v_code, p1_boost}, 0);
        chk("midrst_p2", {p2_h_code, p2_v_code, p2_boost}, 0);
        chk("midrst_byte", byte_data, 0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        key(8'h1B);
        chk("s_after_rst_v", p1_v_code, 2);
        chk("s_after_rst_h", p1_h_code, 0);
        chk("boost_after_rst", {p1_boost, p2_boost}, 0);

        chk("queue_drained", exp_q.size(), 0);
        chk("total_errs", err_cnt, 2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
